snitch_tcdm_bank_arbiter: RTL
=============================

# snitch_tcdm_bank_arbiter

Single-bank TCDM controller placed in front of one data-memory bank of the cluster data memory. Shares the bank's one-port, latency-1 SRAM interface between `NumPorts` requesters with round-robin arbitration and routes the one-cycle-later response back to the granted requester. Also sequences a zero-fill of the whole bank, either automatically out of reset or on request, blocking requesters while it runs.

## Interface
- `NumPorts`, 2: number of requesters sharing the bank (≥2).
- `TCDMDepth`, 512: bank depth in words (power of two); `AW = $clog2(TCDMDepth)`.
- `NarrowDataWidth`, 64: word width; `SW = NarrowDataWidth/8` byte strobes.
- `ClearOnReset`, 1: 1 = zero-fill the bank automatically after reset release.
- `clk_i  in  1  clock`
- `rst_i  in  1  reset; one clock; reset is asynchronous and active-high.`
- `req_i  in  NumPorts  per-port request, held until granted.`
- `we_i  in  NumPorts  per-port write enable (1 = write).`
- `addr_i  in  NumPorts×AW  per-port word address.`
- `be_i  in  NumPorts×SW  per-port byte enables.`
- `wdata_i  in  NumPorts×NarrowDataWidth  per-port write data.`
- `gnt_o  out  NumPorts  one-hot grant, combinational, same cycle as request.`
- `rvalid_o  out  NumPorts  one-hot response valid, one cycle after grant.`
- `rdata_o  out  NarrowDataWidth  read data, broadcast to all ports.`
- `clear_req_i  in  1  start a zero-fill (sampled in IDLE only).`
- `clear_busy_o  out  1  high while zero-fill runs.`
- `clear_done_o  out  1  one-cycle pulse after the last zero-fill write.`
- `mem_cs_o, mem_we_o  out  1 each  SRAM chip select / write enable (active-high).`
- `mem_addr_o  out  AW`, `mem_be_o  out  SW`, `mem_wdata_o  out  NarrowDataWidth`: SRAM request fields.
- `mem_rdata_i  in  NarrowDataWidth  SRAM read data, valid one cycle after `mem_cs_o`.`

## Operation
- FSM states: IDLE, CLEAR. Reset state CLEAR if `ClearOnReset`, else IDLE.
- IDLE: round-robin pointer `rr_q` (reset 0). Winner = first port k with `req_i[k]`, searching `rr_q, rr_q+1, …` modulo NumPorts. `gnt_o[k]=1`; mem fields driven from port k; `mem_cs_o=1`. After a grant to k, `rr_q <= (k+1) mod NumPorts`. No request: `mem_cs_o=0`, `rr_q` unchanged, `mem_*` fields don't-care (drive 0).
- IDLE with `clear_req_i=1`: the same cycle still arbitrates normally; state → CLEAR next cycle.
- CLEAR: `gnt_o=0`; `mem_cs_o=1, mem_we_o=1, mem_be_o=all ones, mem_wdata_o=0, mem_addr_o=cnt_q`. `cnt_q` (reset 0) increments each cycle; at `cnt_q==TCDMDepth-1` → IDLE, `cnt_q<=0`, `clear_done_o` pulses the following cycle. `clear_req_i` ignored in CLEAR. `rr_q` unchanged during CLEAR.
- Response: `rsp_q <= gnt_o` each cycle (reset 0); `rvalid_o = rsp_q`. Issued for reads and writes alike (write acknowledge); `rdata_o = mem_rdata_i` (meaningful only after reads). Clear writes never produce `rvalid_o`.
- Requester may change `we/addr/be/wdata` only after its grant; arbiter does not buffer requests.

## Timing
- Reset values: `gnt_o=0, rvalid_o=0, clear_done_o=0`; `clear_busy_o=ClearOnReset`; `mem_cs_o=ClearOnReset` (clear of address 0 starts in first cycle after reset release).
- Grant: 0-cycle (combinational `req_i`→`gnt_o`). Response: exactly 1 cycle after grant. Throughput: one access per cycle.
- Zero-fill: exactly `TCDMDepth` cycles with `clear_busy_o=1`; `clear_done_o` in the cycle after, first grant possible the same cycle as `clear_done_o`.
- A grant in the cycle before CLEAR still gets its `rvalid_o` during the first CLEAR cycle.
- Reset asserted mid-operation: all state (FSM, `cnt_q`, `rr_q`, `rsp_q`) returns to reset values asynchronously; in-flight responses are dropped; with `ClearOnReset` the fill restarts from address 0.
- `clear_busy_o = (state==CLEAR)`, combinational from state flop.

## Test plan
- NumPorts=3, TCDMDepth=16, ClearOnReset=1: release reset -> `clear_busy_o` high 16 cycles, addresses 0..15 written with 0 and be=0xFF, `clear_done_o` one pulse on cycle 17, no `gnt_o` during fill.
- All three ports request continuously after fill -> grants cycle 0,1,2,0,1,2; each `rvalid_o` one cycle after its grant.
- Port 1 writes 0xDEADBEEF_CAFEF00D to addr 5, then port 2 reads addr 5 -> `rvalid_o[2]` one cycle after its grant with `rdata_o=0xDEADBEEF_CAFEF00D`; partial write be=0x0F then read returns only low 4 bytes updated.
- Only port 2 requesting while `rr_q=0` -> immediate grant to 2, `rr_q` becomes 0; next simultaneous 0 and 2 requests -> port 0 first.
- `clear_req_i` and `req_i[0]` (read addr 3) in the same IDLE cycle -> port 0 granted, `rvalid_o[0]` in first CLEAR cycle, then 16 clear cycles; read of addr 3 afterwards returns 0.
- Assert `rst_i` at clear cycle 7 -> outputs immediately at reset values; after release fill restarts at address 0 and runs full 16 cycles.

Source files
------------

// File: rtl/snitch_tcdm_bank_arbiter.sv
// Single-bank TCDM controller: round-robin sharing of a latency-1 SRAM port
// between NumPorts requesters, plus a sequenced zero-fill of the whole bank.
module snitch_tcdm_bank_arbiter #(
  parameter int unsigned NumPorts        = 2,
  parameter int unsigned TCDMDepth       = 512,
  parameter int unsigned NarrowDataWidth = 64,
  parameter bit          ClearOnReset    = 1'b1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [NumPorts-1:0]                         req_i,
  input  logic [NumPorts-1:0]                         we_i,
  input  logic [NumPorts*$clog2(TCDMDepth)-1:0]       addr_i,
  input  logic [NumPorts*(NarrowDataWidth/8)-1:0]     be_i,
  input  logic [NumPorts*NarrowDataWidth-1:0]         wdata_i,
  output logic [NumPorts-1:0]                         gnt_o,
  output logic [NumPorts-1:0]                         rvalid_o,
  output logic [NarrowDataWidth-1:0]                  rdata_o,
  input  logic                                        clear_req_i,
  output logic                                        clear_busy_o,
  output logic                                        clear_done_o,
  output logic                                        mem_cs_o,
  output logic                                        mem_we_o,
  output logic [$clog2(TCDMDepth)-1:0]                mem_addr_o,
  output logic [NarrowDataWidth/8-1:0]                mem_be_o,
  output logic [NarrowDataWidth-1:0]                  mem_wdata_o,
  input  logic [NarrowDataWidth-1:0]                  mem_rdata_i
);

  localparam int unsigned AW = $clog2(TCDMDepth);
  localparam int unsigned SW = NarrowDataWidth / 8;
  localparam int unsigned PW = $clog2(NumPorts);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  localparam state_e ResetState = ClearOnReset ? CLEAR : IDLE;

  state_e               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [NumPorts-1:0]  rsp_q;
  logic                 done_q, done_d;
  logic                 found;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    done_d      = 1'b0;
    found       = 1'b0;
    gnt_o       = '0;
    mem_cs_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        // Walk offsets from rr_q; rr_q < NumPorts so rr_q+off wraps at most once.
        for (int unsigned off = 0; off < NumPorts; off++) begin
          for (int unsigned k = 0; k < NumPorts; k++) begin
            if (!found && req_i[k] &&
                ((32'(rr_q) + off == k) || (32'(rr_q) + off == k + NumPorts))) begin
              found    = 1'b1;
              gnt_o[k] = 1'b1;
              rr_d     = (k == NumPorts - 1) ? '0 : PW'(k + 1);
            end
          end
        end
        for (int unsigned k = 0; k < NumPorts; k++) begin
          if (gnt_o[k]) begin
            mem_we_o    = we_i[k];
            mem_addr_o  = addr_i[k*AW +: AW];
            mem_be_o    = be_i[k*SW +: SW];
            mem_wdata_o = wdata_i[k*NarrowDataWidth +: NarrowDataWidth];
          end
        end
        mem_cs_o = found;
        if (clear_req_i) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        mem_cs_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = '1;
        mem_wdata_o = '0;
        mem_addr_o  = cnt_q;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == AW'(TCDMDepth - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      rr_q    <= '0;
      rsp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      rsp_q   <= gnt_o;
      done_q  <= done_d;
    end
  end

  assign rvalid_o     = rsp_q;
  assign rdata_o      = mem_rdata_i;
  assign clear_busy_o = (state_q == CLEAR);
  assign clear_done_o = done_q;

endmodule
